// File: rtl/serial_add_unit.sv
// serial_add_unit: bit-serial adder stepping one bit per enabled cycle through a single full adder.
module serial_add_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             s_bit,
  output logic             s_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0] state;
  logic [WIDTH-1:0] ra, rb;
  logic c, s, nc;
  logic [CW-1:0] cnt;
  assign s = ra[0] ^ rb[0] ^ c;
  assign nc = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      c <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      s_bit <= 1'b0;
      s_valid <= 1'b0;
    end else begin
      s_valid <= 1'b0;
      if (load) begin
        ra <= a;
        rb <= b;
        c <= cin;
        cnt <= '0;
        sum <= '0;
        cout <= 1'b0;
        state <= RUN;
      end else if (state == RUN && start) begin
        ra <= {1'b0, ra[WIDTH-1:1]};
        rb <= {1'b0, rb[WIDTH-1:1]};
        sum <= {s, sum[WIDTH-1:1]};
        c <= nc;
        s_bit <= s;
        s_valid <= 1'b1;
        cnt <= cnt + CW'(1);
        if (cnt == LAST) begin
          cout <= nc;
          state <= DONE;
        end
      end
    end
  end
endmodule
